// File: rtl/id_ex_fwd_reg_pkg.sv
// Shared constants for the ID/EX pipeline register and its forwarding-select logic.
package id_ex_fwd_reg_pkg;

  localparam int XLEN          = 32;
  localparam int CTRL_W        = 8;
  localparam int CTRL_REGWRITE = 0;

  typedef enum logic [1:0] {
    FWD_REG   = 2'b00,
    FWD_MEMWB = 2'b01,
    FWD_EXMEM = 2'b10
  } fwd_e;

endpackage

// File: rtl/id_ex_fwd_reg_if.sv
// ID-side payload, stall/flush controls and registered EX-side outputs of the ID/EX register.
// Optional bubble counter port is present when ID_EX_BUBBLE_CNT_EN is defined.
interface id_ex_fwd_reg_if #(
  parameter int XLEN   = id_ex_fwd_reg_pkg::XLEN,
  parameter int CTRL_W = id_ex_fwd_reg_pkg::CTRL_W
);

  logic              hold_i;
  logic              flush_i;
  logic              id_valid_i;
  logic [XLEN-1:0]   id_pc_i;
  logic [XLEN-1:0]   id_rs1_data_i;
  logic [XLEN-1:0]   id_rs2_data_i;
  logic [XLEN-1:0]   id_imm_i;
  logic [4:0]        id_rs1_addr_i;
  logic [4:0]        id_rs2_addr_i;
  logic [4:0]        id_rd_addr_i;
  logic [CTRL_W-1:0] id_ctrl_i;
  logic [4:0]        ex_rd_addr_q_i;
  logic              ex_regwrite_q_i;

  logic              ex_valid_o;
  logic [XLEN-1:0]   ex_pc_o;
  logic [XLEN-1:0]   ex_rs1_data_o;
  logic [XLEN-1:0]   ex_rs2_data_o;
  logic [XLEN-1:0]   ex_imm_o;
  logic [4:0]        ex_rs1_addr_o;
  logic [4:0]        ex_rs2_addr_o;
  logic [4:0]        ex_rd_addr_o;
  logic [CTRL_W-1:0] ex_ctrl_o;
  logic [1:0]        ex_fwd_a_o;
  logic [1:0]        ex_fwd_b_o;
`ifdef ID_EX_BUBBLE_CNT_EN
  logic [31:0]       bubble_cnt_o;
`endif

  modport master (
    output hold_i, flush_i, id_valid_i, id_pc_i, id_rs1_data_i, id_rs2_data_i, id_imm_i,
           id_rs1_addr_i, id_rs2_addr_i, id_rd_addr_i, id_ctrl_i, ex_rd_addr_q_i, ex_regwrite_q_i,
    input  ex_valid_o, ex_pc_o, ex_rs1_data_o, ex_rs2_data_o, ex_imm_o,
           ex_rs1_addr_o, ex_rs2_addr_o, ex_rd_addr_o, ex_ctrl_o, ex_fwd_a_o, ex_fwd_b_o
`ifdef ID_EX_BUBBLE_CNT_EN
    , input bubble_cnt_o
`endif
  );

  modport slave (
    input  hold_i, flush_i, id_valid_i, id_pc_i, id_rs1_data_i, id_rs2_data_i, id_imm_i,
           id_rs1_addr_i, id_rs2_addr_i, id_rd_addr_i, id_ctrl_i, ex_rd_addr_q_i, ex_regwrite_q_i,
    output ex_valid_o, ex_pc_o, ex_rs1_data_o, ex_rs2_data_o, ex_imm_o,
           ex_rs1_addr_o, ex_rs2_addr_o, ex_rd_addr_o, ex_ctrl_o, ex_fwd_a_o, ex_fwd_b_o
`ifdef ID_EX_BUBBLE_CNT_EN
    , output bubble_cnt_o
`endif
  );

endinterface

// File: rtl/id_ex_fwd_reg_fwd_sel.sv
// Combinational source-register vs. producer-destination compare for one EX operand.
module fwd_sel (
  input  logic [4:0] rs_addr,
  input  logic [4:0] exmem_rd,
  input  logic       exmem_we,
  input  logic [4:0] memwb_rd,
  input  logic       memwb_we,
  output logic [1:0] sel
);
  import id_ex_fwd_reg_pkg::*;

  // The instruction currently in EX is younger than the one in MEM, so it wins.
  always_comb begin
    sel = FWD_REG;
    if (rs_addr != 5'd0) begin
      if (exmem_we && (exmem_rd != 5'd0) && (exmem_rd == rs_addr)) begin
        sel = FWD_EXMEM;
      end else if (memwb_we && (memwb_rd != 5'd0) && (memwb_rd == rs_addr)) begin
        sel = FWD_MEMWB;
      end
    end
  end

endmodule

// File: rtl/id_ex_fwd_reg.sv
// ID/EX pipeline register with forwarding selects precomputed at load time.
// Define ID_EX_BUBBLE_CNT_EN to add a free-running count of loaded bubbles.
module id_ex_fwd_reg #(
  parameter int XLEN   = id_ex_fwd_reg_pkg::XLEN,
  parameter int CTRL_W = id_ex_fwd_reg_pkg::CTRL_W
) (
  input  logic            clk_i,
  input  logic            rst_i,
  id_ex_fwd_reg_if.slave  bus
);
  import id_ex_fwd_reg_pkg::FWD_REG;
  import id_ex_fwd_reg_pkg::CTRL_REGWRITE;

  logic              valid_p1;
  logic [XLEN-1:0]   pc_p1;
  logic [XLEN-1:0]   rs1_data_p1;
  logic [XLEN-1:0]   rs2_data_p1;
  logic [XLEN-1:0]   imm_p1;
  logic [4:0]        rs1_addr_p1;
  logic [4:0]        rs2_addr_p1;
  logic [4:0]        rd_addr_p1;
  logic [CTRL_W-1:0] ctrl_p1;
  logic [1:0]        fwd_a_p1;
  logic [1:0]        fwd_b_p1;

  logic [1:0]        fwd_a_p0;
  logic [1:0]        fwd_b_p0;
  logic              exmem_we_p0;

  // Stage p0: match against the instruction now in EX (moves to MEM) and the one now in MEM.
  assign exmem_we_p0 = valid_p1 & ctrl_p1[CTRL_REGWRITE];

  fwd_sel u_fwd_a (
    .rs_addr  (bus.id_rs1_addr_i),
    .exmem_rd (rd_addr_p1),
    .exmem_we (exmem_we_p0),
    .memwb_rd (bus.ex_rd_addr_q_i),
    .memwb_we (bus.ex_regwrite_q_i),
    .sel      (fwd_a_p0)
  );

  fwd_sel u_fwd_b (
    .rs_addr  (bus.id_rs2_addr_i),
    .exmem_rd (rd_addr_p1),
    .exmem_we (exmem_we_p0),
    .memwb_rd (bus.ex_rd_addr_q_i),
    .memwb_we (bus.ex_regwrite_q_i),
    .sel      (fwd_b_p0)
  );

  // Stage p1: the EX-side register; an invalid ID slot loads payload but no side effects.
  always_ff @(posedge clk_i) begin
    if (rst_i || (!bus.hold_i && bus.flush_i)) begin
      valid_p1    <= 1'b0;
      pc_p1       <= '0;
      rs1_data_p1 <= '0;
      rs2_data_p1 <= '0;
      imm_p1      <= '0;
      rs1_addr_p1 <= '0;
      rs2_addr_p1 <= '0;
      rd_addr_p1  <= '0;
      ctrl_p1     <= '0;
      fwd_a_p1    <= FWD_REG;
      fwd_b_p1    <= FWD_REG;
    end else if (!bus.hold_i) begin
      valid_p1    <= bus.id_valid_i;
      pc_p1       <= bus.id_pc_i;
      rs1_data_p1 <= bus.id_rs1_data_i;
      rs2_data_p1 <= bus.id_rs2_data_i;
      imm_p1      <= bus.id_imm_i;
      rs1_addr_p1 <= bus.id_rs1_addr_i;
      rs2_addr_p1 <= bus.id_rs2_addr_i;
      if (bus.id_valid_i) begin
        rd_addr_p1 <= bus.id_rd_addr_i;
        ctrl_p1    <= bus.id_ctrl_i;
        fwd_a_p1   <= fwd_a_p0;
        fwd_b_p1   <= fwd_b_p0;
      end else begin
        rd_addr_p1 <= '0;
        ctrl_p1    <= '0;
        fwd_a_p1   <= FWD_REG;
        fwd_b_p1   <= FWD_REG;
      end
    end
  end

  assign bus.ex_valid_o    = valid_p1;
  assign bus.ex_pc_o       = pc_p1;
  assign bus.ex_rs1_data_o = rs1_data_p1;
  assign bus.ex_rs2_data_o = rs2_data_p1;
  assign bus.ex_imm_o      = imm_p1;
  assign bus.ex_rs1_addr_o = rs1_addr_p1;
  assign bus.ex_rs2_addr_o = rs2_addr_p1;
  assign bus.ex_rd_addr_o  = rd_addr_p1;
  assign bus.ex_ctrl_o     = ctrl_p1;
  assign bus.ex_fwd_a_o    = fwd_a_p1;
  assign bus.ex_fwd_b_o    = fwd_b_p1;

`ifdef ID_EX_BUBBLE_CNT_EN
  logic [31:0] bubble_cnt_p1;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bubble_cnt_p1 <= '0;
    end else if (!bus.hold_i && (bus.flush_i || !bus.id_valid_i)) begin
      bubble_cnt_p1 <= bubble_cnt_p1 + 32'd1;
    end
  end

  assign bus.bubble_cnt_o = bubble_cnt_p1;
`endif

endmodule

// File: doc/id_ex_fwd_reg.md
ID_EX_FWD_REG -- requirements
Module: id_ex_fwd_reg

Interface
REQ-001 Parameter: XLEN, 32, datapath width; CTRL_W, 8, control-bundle width (bit 0 = RegWrite).
REQ-002 clk_i  in  1  single clock; all state updates on rising edge.
REQ-003 rst_i  in  1  synchronous, active-high reset.
REQ-004 hold_i  in  1  freeze register (global pipeline stall).
REQ-005 flush_i  in  1  load bubble instead of ID instruction.
REQ-006 id_valid_i  in  1; id_pc_i, id_rs1_data_i, id_rs2_data_i, id_imm_i  in  XLEN  ID-stage payload.
REQ-007 id_rs1_addr_i, id_rs2_addr_i, id_rd_addr_i  in  5; id_ctrl_i  in  CTRL_W.
REQ-008 ex_rd_addr_q_i  in  5, ex_regwrite_q_i  in  1  EX/MEM-register destination (instruction now in MEM).
REQ-009 ex_valid_o  out 1; ex_pc_o, ex_rs1_data_o, ex_rs2_data_o, ex_imm_o  out  XLEN; ex_rs1_addr_o, ex_rs2_addr_o, ex_rd_addr_o  out  5; ex_ctrl_o  out  CTRL_W.
REQ-010 ex_fwd_a_o, ex_fwd_b_o  out  2  select for EX operand 4:1 muxes: 00 register value, 01 MEM/WB result, 10 EX/MEM result, 11 never driven.
REQ-011 bubble_cnt_o  out  32  bubbles loaded (present only with macro, REQ-027).

Function
REQ-012 Edge priority SHALL be: rst_i > hold_i > flush_i > load.
REQ-013 hold_i=1: every output register SHALL keep its value, including ex_fwd_*_o.
REQ-014 flush_i=1, hold_i=0: ex_valid_o<=0, ex_ctrl_o<=0, ex_rd_addr_o<=0, ex_fwd_*_o<=00; data/pc/imm/addr fields don't-care but SHALL be zeroed.
REQ-015 Load (hold_i=0, flush_i=0): all ex_* payload outputs <= corresponding id_* inputs, one-cycle latency; ex_valid_o<=id_valid_i.
REQ-016 id_valid_i=0 on load SHALL be treated as bubble: ex_ctrl_o<=0, ex_rd_addr_o<=0, ex_fwd_*_o<=00.
REQ-017 Forward selects SHALL be precomputed at load time and registered; no combinational path from any input to ex_fwd_*_o.
REQ-018 EX/MEM match (next cycle): ex_valid_o=1, ex_ctrl_o[0]=1, ex_rd_addr_o!=0, ex_rd_addr_o==id_rsN_addr_i -> select 10.
REQ-019 MEM/WB match (next cycle): ex_regwrite_q_i=1, ex_rd_addr_q_i!=0, ex_rd_addr_q_i==id_rsN_addr_i -> select 01.
REQ-020 Both match: 10 SHALL win (youngest producer). Neither: 00.
REQ-021 rsN_addr==0 SHALL always yield 00.
REQ-022 Match terms use current register contents (pre-edge), evaluated identically for rs1 (fwd_a) and rs2 (fwd_b).
REQ-023 Same-cycle writeback to regfile for ID read is handled by regfile bypass; out of scope.

Reset
REQ-024 rst_i=1 at edge: all outputs <= 0 (ex_fwd_*_o=00, bubble_cnt_o=0), regardless of hold_i/flush_i.
REQ-025 Reset mid-stall: state cleared; first post-reset load behaves as REQ-015.

Configuration
REQ-026 Macro ID_EX_BUBBLE_CNT_EN controls bubble counter.
REQ-027 Defined: bubble_cnt_o present; increments by 1 on each non-hold edge that loads a bubble (flush_i=1 or id_valid_i=0); wraps 0xFFFFFFFF->0; held during hold_i.
REQ-028 Undefined: port and counter absent; all other behaviour identical.

Structure
REQ-029 Shared package SHALL hold: FWD_REG=2'b00, FWD_MEMWB=2'b01, FWD_EXMEM=2'b10, CTRL_W, CTRL_REGWRITE bit index.
REQ-030 One sub-module fwd_sel (combinational rs/rd compare, instantiated twice for rs1/rs2); all registers in id_ex_fwd_reg.

Verification
REQ-031 Reset with hold_i=1 and nonzero inputs -> all outputs 0 next cycle.
REQ-032 Load add x5 (rd=5,RegWrite) then sub rs1=x5,rs2=x6 -> ex_fwd_a_o=10, ex_fwd_b_o=00 on second instruction.
REQ-033 ex_rd_addr_q_i=7/regwrite=1 and current ex_rd=7 RegWrite, load rs2=x7 -> ex_fwd_b_o=10; with current EX not writing -> 01.
REQ-034 rs1=x0 with both producers rd=0 RegWrite -> ex_fwd_a_o=00.
REQ-035 hold_i=1 for 3 cycles with changing id_* -> outputs unchanged; hold_i+flush_i together -> no bubble, counter unchanged.
REQ-036 Macro defined: 4 flushes + 1 id_valid_i=0 load -> bubble_cnt_o=5; preload 0xFFFFFFFF then flush -> 0.
